dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Arbitrates the single-port data memory (MemDatos) between two requesters: the CPU EM-stage load/store, and the VGA scanout burst reader.
- Grants at most one memory access per cycle.
- Stalls the CPU pipeline while its request is pending.
- Bounds CPU wait during VGA line bursts with a starvation counter.

Parameters:
ADDR_W, 10, data memory word-address width
DATA_W, 32, data word width
BURST_LEN, 8, words fetched per VGA burst (2..255)
MAX_WAIT, 3, consecutive cycles a CPU request may be refused before it is forced through (1..15)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cpu_req  in  1  CPU access request; held with addr/we/wdata stable until cpu_gnt
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU write data
cpu_gnt  out  1  CPU access issued this cycle
cpu_stall  out  1  cpu_req & ~cpu_gnt; freezes PC/pipe registers
cpu_rvalid  out  1  CPU read data valid (cycle after read grant)
cpu_rdata  out  DATA_W  CPU read data
vga_req  in  1  request for a new burst starting at vga_addr
vga_addr  in  ADDR_W  burst base address
vga_ack  out  1  one-cycle pulse: burst accepted, vga_addr captured
vga_rvalid  out  1  one burst word valid
vga_rdata  out  DATA_W  burst word
vga_done  out  1  one-cycle pulse with the last vga_rvalid
mem_addr  out  ADDR_W  RAM address
mem_we  out  1  RAM write enable
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data; 1-cycle synchronous read latency

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; beat_cnt=0; base=0; wait_cnt=0; ret_tag=NONE.
  - All grant, valid, ack, done and mem_we outputs are 0 while rst_n=0; mem_addr and mem_wdata are 0.
  - A burst in progress is aborted; no rvalid or done appears after release.
- FSM states are IDLE and BURST.
- IDLE:
  - If cpu_req, the CPU is granted; the access is issued combinationally on mem_* this cycle.
  - If vga_req, vga_ack=1, base<=vga_addr, beat_cnt<=0, go to BURST. Acceptance uses no memory slot, so a CPU grant in the same cycle is allowed.
- BURST:
  - Default: issue VGA beat at mem_addr=(base+beat_cnt) mod 2^ADDR_W, mem_we=0; beat_cnt++.
  - Exception: if cpu_req and wait_cnt==MAX_WAIT, the CPU is granted instead and the beat is deferred (beat_cnt unchanged).
  - After issuing beat BURST_LEN-1, go to IDLE.
  - vga_req is ignored in BURST (no ack).
- wait_cnt:
  - Increments each cycle cpu_req=1 and cpu_gnt=0, saturating at MAX_WAIT.
  - Cleared on cpu_gnt or when cpu_req=0.
- Read return:
  - ret_tag registers the owner of each issued read (CPU read, VGA beat, or NONE). CPU writes give NONE.
  - In the next cycle, rdata=mem_rdata, and cpu_rvalid or vga_rvalid is 1 per ret_tag.
  - vga_done=1 with the rvalid of beat BURST_LEN-1.
  - Throughput: 1 access/cycle. Read latency: 1 cycle from grant.
- CPU write: mem_we=1, mem_addr=cpu_addr, mem_wdata=cpu_wdata in the grant cycle. No rvalid.
- Idle cycle (nothing issued): mem_we=0, mem_addr holds last value (don't-care), ret_tag<=NONE.
- Address wrap: base+beat_cnt wraps modulo 2^ADDR_W.
- Back-to-back bursts: a new vga_req is accepted in the first IDLE cycle after the last beat issue. That ack may coincide with the previous burst's vga_done.
- Worst-case CPU stall: MAX_WAIT cycles in BURST. In IDLE, 0 stall.

Test Plan:
- Reset release, cpu_req read addr 5 (RAM[5]=0xDEADBEEF) -> cpu_gnt same cycle, cpu_stall=0, next cycle cpu_rvalid=1, cpu_rdata=0xDEADBEEF.
- BURST_LEN=8, vga_req addr 0x3FC, no CPU traffic:
  - vga_ack 1 cycle.
  - Beats issued to 0x3FC,0x3FD,0x3FE,0x3FF,0x000..0x003.
  - 8 consecutive vga_rvalid; vga_done with the 8th.
  - FSM returns to IDLE.
- MAX_WAIT=3, cpu_req write 0x1234 to addr 7 asserted on the first BURST cycle:
  - cpu_stall=1 for 3 cycles, then cpu_gnt with mem_we=1 and mem_addr=7.
  - The VGA beat is deferred one cycle; all 8 beats still delivered in order.
- Same cycle in IDLE, cpu_req read plus vga_req -> cpu_gnt=1 and vga_ack=1 together; CPU data next cycle; burst beats start the following cycle.
- rst_n pulsed low after beat 3 of a burst -> all outputs 0 immediately. After release: no vga_rvalid/vga_done, state IDLE, a new vga_req is acked.
- vga_req held high through an entire burst -> exactly one ack during BURST; a second ack in the first IDLE cycle after the last beat issue.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Single-port data memory arbiter between the CPU EM-stage and the VGA burst reader.
// One access per cycle; CPU is forced through a VGA burst after MAX_WAIT refused cycles.
module dmem_port_arbiter #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned BURST_LEN = 8,
    parameter int unsigned MAX_WAIT  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_ack,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              vga_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {StIdle, StBurst} state_t;
    typedef enum logic [1:0] {TagNone, TagCpu, TagVga} tag_t;

    state_t            r_state;
    state_t            w_state_d;
    logic [7:0]        r_beat_cnt;
    logic [7:0]        w_beat_cnt_d;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] w_base_d;
    logic [3:0]        r_wait_cnt;
    logic [3:0]        w_wait_cnt_d;
    tag_t              r_ret_tag;
    tag_t              w_ret_tag_d;
    logic              r_ret_last;
    logic              w_ret_last_d;
    logic [ADDR_W-1:0] r_last_addr;

    logic              w_cpu_gnt;
    logic              w_vga_ack;
    logic              w_vga_issue;
    logic              w_last_beat;
    logic [ADDR_W-1:0] w_beat_addr;
    logic [ADDR_W-1:0] w_mem_addr;

    assign w_beat_addr = r_base + ADDR_W'(r_beat_cnt);
    assign w_last_beat = (r_beat_cnt == 8'(BURST_LEN - 1));

    always_comb begin
        w_state_d    = r_state;
        w_beat_cnt_d = r_beat_cnt;
        w_base_d     = r_base;
        w_cpu_gnt    = 1'b0;
        w_vga_ack    = 1'b0;
        w_vga_issue  = 1'b0;
        unique case (r_state)
            StIdle: begin
                // Burst acceptance takes no memory slot, so the CPU may share the cycle.
                w_cpu_gnt = cpu_req;
                if (vga_req) begin
                    w_vga_ack    = 1'b1;
                    w_base_d     = vga_addr;
                    w_beat_cnt_d = '0;
                    w_state_d    = StBurst;
                end
            end
            StBurst: begin
                if (cpu_req && (r_wait_cnt == 4'(MAX_WAIT))) begin
                    w_cpu_gnt = 1'b1;
                end else begin
                    w_vga_issue  = 1'b1;
                    w_beat_cnt_d = r_beat_cnt + 8'd1;
                    if (w_last_beat) begin
                        w_state_d = StIdle;
                    end
                end
            end
        endcase
    end

    always_comb begin
        w_wait_cnt_d = r_wait_cnt;
        if (!cpu_req || w_cpu_gnt) begin
            w_wait_cnt_d = '0;
        end else if (r_wait_cnt != 4'(MAX_WAIT)) begin
            w_wait_cnt_d = r_wait_cnt + 4'd1;
        end
    end

    always_comb begin
        w_ret_tag_d  = TagNone;
        w_ret_last_d = 1'b0;
        if (w_cpu_gnt && !cpu_we) begin
            w_ret_tag_d = TagCpu;
        end else if (w_vga_issue) begin
            w_ret_tag_d  = TagVga;
            w_ret_last_d = w_last_beat;
        end
    end

    always_comb begin
        w_mem_addr = r_last_addr;
        if (w_cpu_gnt) begin
            w_mem_addr = cpu_addr;
        end else if (w_vga_issue) begin
            w_mem_addr = w_beat_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_beat_cnt  <= '0;
            r_base      <= '0;
            r_wait_cnt  <= '0;
            r_ret_tag   <= TagNone;
            r_ret_last  <= 1'b0;
            r_last_addr <= '0;
        end else begin
            r_state     <= w_state_d;
            r_beat_cnt  <= w_beat_cnt_d;
            r_base      <= w_base_d;
            r_wait_cnt  <= w_wait_cnt_d;
            r_ret_tag   <= w_ret_tag_d;
            r_ret_last  <= w_ret_last_d;
            r_last_addr <= w_mem_addr;
        end
    end

    // Combinational outputs are gated so everything reads 0 while reset is held.
    assign cpu_gnt    = rst_n & w_cpu_gnt;
    assign cpu_stall  = rst_n & cpu_req & ~w_cpu_gnt;
    assign vga_ack    = rst_n & w_vga_ack;
    assign mem_we     = rst_n & w_cpu_gnt & cpu_we;
    assign mem_addr   = rst_n ? w_mem_addr : '0;
    assign mem_wdata  = rst_n ? cpu_wdata : '0;
    assign cpu_rvalid = (r_ret_tag == TagCpu);
    assign vga_rvalid = (r_ret_tag == TagVga);
    assign vga_done   = (r_ret_tag == TagVga) & r_ret_last;
    assign cpu_rdata  = rst_n ? mem_rdata : '0;
    assign vga_rdata  = rst_n ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized bench for dmem_port_arbiter against a queue-based reference model.
// A behavioural synchronous RAM sits on the mem_* side.
module tb_dmem_port_arbiter;

    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 32;
    localparam int BURST_LEN = 8;
    localparam int MAX_WAIT  = 3;
    localparam int DEPTH     = 1 << ADDR_W;

    logic              clk;
    logic              rst_n;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_ack;
    logic              vga_rvalid;
    logic [DATA_W-1:0] vga_rdata;
    logic              vga_done;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    dmem_port_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .BURST_LEN(BURST_LEN),
        .MAX_WAIT (MAX_WAIT)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_gnt   (cpu_gnt),
        .cpu_stall (cpu_stall),
        .cpu_rvalid(cpu_rvalid),
        .cpu_rdata (cpu_rdata),
        .vga_req   (vga_req),
        .vga_addr  (vga_addr),
        .vga_ack   (vga_ack),
        .vga_rvalid(vga_rvalid),
        .vga_rdata (vga_rdata),
        .vga_done  (vga_done),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DATA_W-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    // Reference model: pending burst is a queue of word addresses still to fetch.
    logic [DATA_W-1:0] ref_mem [DEPTH];
    int                q_beats[$];
    bit                m_busy;
    int                m_wait;
    bit                p_cpu, p_vga, p_done;
    logic [DATA_W-1:0] p_data;
    bit                e_gnt, e_ack;
    bit                cpu_pending;
    int                n_checks, n_errors;
    int                stall_seen, ack_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        q_beats.delete();
        m_wait = 0;
        p_cpu  = 1'b0;
        p_vga  = 1'b0;
        p_done = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_gnt"},    cpu_gnt,    0);
        check({tag, "_stall"},  cpu_stall,  0);
        check({tag, "_crv"},    cpu_rvalid, 0);
        check({tag, "_ack"},    vga_ack,    0);
        check({tag, "_vrv"},    vga_rvalid, 0);
        check({tag, "_done"},   vga_done,   0);
        check({tag, "_we"},     mem_we,     0);
        check({tag, "_addr"},   mem_addr,   0);
        check({tag, "_wdata"},  mem_wdata,  0);
    endtask

    // Entered at posedge+1 with inputs applied; returns at the next posedge+1.
    task automatic cycle();
        int a;
        #4;
        e_gnt = cpu_req && (!m_busy || m_wait == MAX_WAIT);
        e_ack = !m_busy && vga_req;
        check("cpu_gnt",    cpu_gnt,    e_gnt);
        check("cpu_stall",  cpu_stall,  cpu_req && !e_gnt);
        check("vga_ack",    vga_ack,    e_ack);
        check("cpu_rvalid", cpu_rvalid, p_cpu);
        check("vga_rvalid", vga_rvalid, p_vga);
        check("vga_done",   vga_done,   p_done);
        if (p_cpu) check("cpu_rdata", cpu_rdata, p_data);
        if (p_vga) check("vga_rdata", vga_rdata, p_data);
        p_cpu  = 1'b0;
        p_vga  = 1'b0;
        p_done = 1'b0;
        if (e_gnt) begin
            check("cpu_mem_we",   mem_we,   cpu_we);
            check("cpu_mem_addr", mem_addr, cpu_addr);
            if (cpu_we) begin
                check("cpu_mem_wdata", mem_wdata, cpu_wdata);
                ref_mem[cpu_addr] = cpu_wdata;
            end else begin
                p_cpu  = 1'b1;
                p_data = ref_mem[cpu_addr];
            end
        end else begin
            check("mem_we_idle", mem_we, 0);
            if (m_busy) begin
                a = q_beats.pop_front();
                check("beat_addr", mem_addr, a);
                p_vga  = 1'b1;
                p_data = ref_mem[a];
                p_done = (q_beats.size() == 0);
                if (q_beats.size() == 0) m_busy = 1'b0;
            end
        end
        if (e_ack) begin
            m_busy = 1'b1;
            for (int i = 0; i < BURST_LEN; i++) q_beats.push_back((int'(vga_addr) + i) % DEPTH);
        end
        if (!cpu_req || e_gnt) m_wait = 0;
        else if (m_wait < MAX_WAIT) m_wait++;
        stall_seen += int'(cpu_stall);
        ack_seen   += int'(vga_ack);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_cycles(input int n, input int vga_odds);
        for (int k = 0; k < n; k++) begin
            if (!cpu_pending) begin
                cpu_req   = ($urandom % 3) == 0;
                cpu_we    = $urandom % 2;
                cpu_addr  = ADDR_W'($urandom);
                cpu_wdata = $urandom;
            end
            vga_req  = ($urandom % vga_odds) == 0;
            vga_addr = ($urandom % 4 == 0) ? ADDR_W'(DEPTH - 1 - ($urandom % 4)) : ADDR_W'($urandom);
            cycle();
            cpu_pending = cpu_req && !e_gnt;
        end
        cpu_req     = 1'b0;
        vga_req     = 1'b0;
        cpu_pending = 1'b0;
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        stall_seen  = 0;
        ack_seen    = 0;
        cpu_pending = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]     = $urandom;
            ref_mem[i] = ram[i];
        end
        ram[5]     = 32'hDEADBEEF;
        ref_mem[5] = 32'hDEADBEEF;
        model_reset();

        rst_n     = 1'b0;
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 10'h155;
        cpu_wdata = 32'hFFFF_FFFF;
        vga_req   = 1'b1;
        vga_addr  = 10'h2AA;
        #2;
        check_zero("rst");
        cpu_req = 1'b0;
        vga_req = 1'b0;
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // CPU read right after reset.
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 10'd5;
        cycle();
        cpu_req = 1'b0;
        cycle();

        // Wrapping burst with no CPU traffic.
        vga_req  = 1'b1;
        vga_addr = 10'h3FC;
        cycle();
        vga_req = 1'b0;
        repeat (BURST_LEN + 1) cycle();

        // CPU write forced through on the first burst cycle.
        vga_req  = 1'b1;
        vga_addr = 10'h100;
        cycle();
        vga_req    = 1'b0;
        stall_seen = 0;
        cpu_req    = 1'b1;
        cpu_we     = 1'b1;
        cpu_addr   = 10'd7;
        cpu_wdata  = 32'h1234;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (e_gnt) break;
        end
        cpu_req = 1'b0;
        check("starve_stall_cycles", stall_seen, MAX_WAIT);
        repeat (BURST_LEN + 1) cycle();
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 10'd7;
        cycle();
        cpu_req = 1'b0;
        cycle();

        // CPU read and burst request in the same idle cycle.
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 10'd5;
        vga_req  = 1'b1;
        vga_addr = 10'h020;
        cycle();
        cpu_req = 1'b0;
        vga_req = 1'b0;
        repeat (BURST_LEN + 1) cycle();

        // Reset in the middle of a burst.
        vga_req  = 1'b1;
        vga_addr = 10'h040;
        cycle();
        vga_req = 1'b0;
        repeat (4) cycle();
        #2;
        rst_n     = 1'b0;
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_wdata = 32'hA5A5_A5A5;
        #1;
        check_zero("midrst");
        model_reset();
        cpu_req = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) cycle();
        vga_req  = 1'b1;
        vga_addr = 10'h080;
        ack_seen = 0;
        cycle();
        check("post_rst_ack", ack_seen, 1);
        vga_req = 1'b0;
        repeat (BURST_LEN + 1) cycle();

        // vga_req held through a whole burst.
        vga_req  = 1'b1;
        vga_addr = 10'h0C0;
        ack_seen = 0;
        repeat (BURST_LEN + 2) cycle();
        check("held_req_acks", ack_seen, 2);
        vga_req = 1'b0;
        repeat (BURST_LEN + 1) cycle();

        rand_cycles(2000, 6);
        rand_cycles(2000, 2);
        repeat (BURST_LEN + 2) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
